// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32 pipeline control blocks.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    // Destination tracking for one pipeline stage.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  load;
    } stage_dst_t;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one source operand against one stage destination; x0 never matches.
module hazard_cmp
    import cpu_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic                  src_used,
    input  stage_dst_t            dst,
    output logic                  match
);

    assign match = src_used & dst.wr & (dst.rd == src_addr) & (src_addr != REG_X0);

endmodule

// File: rtl/hazard_forward_unit.sv
// ID/EXE hazard detection and forwarding control: tracks EXE/MEM destinations,
// registers operand forwarding flags for the instruction entering EXE, and
// raises a one-cycle load-use stall with a performance counter.
module hazard_forward_unit #(
    parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_mem,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic                  rs1_exe_hazard,
    output logic                  rs1_mem_hazard,
    output logic                  rs2_exe_hazard,
    output logic                  rs2_mem_hazard,
    output logic                  load_use_stall,
    output logic [CNT_W-1:0]      stall_cnt
);

    cpu_pkg::stage_dst_t exe_dst;
    cpu_pkg::stage_dst_t mem_dst;

    logic m_rs1_exe;
    logic m_rs2_exe;
    logic m_rs1_mem;
    logic m_rs2_mem;
    logic lu_rs1;
    logic lu_rs2;

    hazard_cmp u_cmp_rs1_exe (
        .src_addr (id_rs1_addr),
        .src_used (id_rs1_used),
        .dst      (exe_dst),
        .match    (m_rs1_exe)
    );

    hazard_cmp u_cmp_rs2_exe (
        .src_addr (id_rs2_addr),
        .src_used (id_rs2_used),
        .dst      (exe_dst),
        .match    (m_rs2_exe)
    );

    hazard_cmp u_cmp_rs1_mem (
        .src_addr (id_rs1_addr),
        .src_used (id_rs1_used),
        .dst      (mem_dst),
        .match    (m_rs1_mem)
    );

    hazard_cmp u_cmp_rs2_mem (
        .src_addr (id_rs2_addr),
        .src_used (id_rs2_used),
        .dst      (mem_dst),
        .match    (m_rs2_mem)
    );

    hazard_cmp u_cmp_lu_rs1 (
        .src_addr (id_rs1_addr),
        .src_used (id_rs1_used),
        .dst      (exe_dst),
        .match    (lu_rs1)
    );

    hazard_cmp u_cmp_lu_rs2 (
        .src_addr (id_rs2_addr),
        .src_used (id_rs2_used),
        .dst      (exe_dst),
        .match    (lu_rs2)
    );

    // Load in EXE feeding an operand of the real instruction in ID; deliberately not gated by stall_mem.
    assign load_use_stall = id_valid & ~flush & exe_dst.load & exe_dst.wr & (lu_rs1 | lu_rs2);

    // Stage destination and forwarding-flag registers; flush/bubble/load-use all insert a bubble into EXE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_dst        <= '0;
            mem_dst        <= '0;
            rs1_exe_hazard <= 1'b0;
            rs1_mem_hazard <= 1'b0;
            rs2_exe_hazard <= 1'b0;
            rs2_mem_hazard <= 1'b0;
        end else if (!stall_mem) begin
            mem_dst <= '{rd: exe_dst.rd, wr: exe_dst.wr, load: 1'b0};
            if (flush || !id_valid || load_use_stall) begin
                exe_dst        <= '0;
                rs1_exe_hazard <= 1'b0;
                rs1_mem_hazard <= 1'b0;
                rs2_exe_hazard <= 1'b0;
                rs2_mem_hazard <= 1'b0;
            end else begin
                exe_dst        <= '{rd: id_rd_addr, wr: id_reg_write, load: id_mem_read};
                rs1_exe_hazard <= m_rs1_exe;
                rs1_mem_hazard <= m_rs1_mem;
                rs2_exe_hazard <= m_rs2_exe;
                rs2_mem_hazard <= m_rs2_mem;
            end
        end
    end

    // Counts advance cycles spent in a load-use stall; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!stall_mem && load_use_stall) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: scoreboard of expected
// stall/flag/counter values pushed at drive time and popped at sample time,
// plus fixed expectations for each instruction-sequence scenario.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_mem;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        rs1_exe_hazard;
    logic        rs1_mem_hazard;
    logic        rs2_exe_hazard;
    logic        rs2_mem_hazard;
    logic        load_use_stall;
    logic [31:0] stall_cnt;

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_mem      (stall_mem),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rd_addr     (id_rd_addr),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .rs1_exe_hazard (rs1_exe_hazard),
        .rs1_mem_hazard (rs1_mem_hazard),
        .rs2_exe_hazard (rs2_exe_hazard),
        .rs2_mem_hazard (rs2_mem_hazard),
        .load_use_stall (load_use_stall),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  flags;  // {rs1_exe, rs1_mem, rs2_exe, rs2_mem}
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    logic stall_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [4:0]  m_exe_rd;
    logic        m_exe_wr;
    logic        m_exe_ld;
    logic [4:0]  m_mem_rd;
    logic        m_mem_wr;
    logic [3:0]  m_flags;
    logic [31:0] m_cnt;

    // DUT stall value observed in the most recent step
    logic seen_stall;

    function automatic logic mt(input logic used, input logic [4:0] a,
                                input logic wr, input logic [4:0] rd);
        return used & wr & (rd == a) & (a != 5'd0);
    endfunction

    task automatic model_reset();
        m_exe_rd = '0; m_exe_wr = 1'b0; m_exe_ld = 1'b0;
        m_mem_rd = '0; m_mem_wr = 1'b0;
        m_flags  = '0; m_cnt    = '0;
        exp_q.delete();
        stall_q.delete();
    endtask

    // One pipeline cycle: drive ID at negedge, check stall before the edge,
    // check registered flags and counter after the edge.
    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic sm, input logic fl);
        logic lus;
        exp_t e;
        exp_t got_e;
        logic got_s;
        logic [3:0] obs;
        @(negedge clk);
        id_valid = v; id_rs1_addr = rs1; id_rs2_addr = rs2;
        id_rs1_used = u1; id_rs2_used = u2; id_rd_addr = rd;
        id_reg_write = wr; id_mem_read = ld; stall_mem = sm; flush = fl;

        lus = v & ~fl & m_exe_ld & m_exe_wr &
              (mt(u1, rs1, m_exe_wr, m_exe_rd) | mt(u2, rs2, m_exe_wr, m_exe_rd));
        stall_q.push_back(lus);
        if (!sm) begin
            if (fl || !v || lus) begin
                m_flags = '0;
            end else begin
                m_flags = {mt(u1, rs1, m_exe_wr, m_exe_rd), mt(u1, rs1, m_mem_wr, m_mem_rd),
                           mt(u2, rs2, m_exe_wr, m_exe_rd), mt(u2, rs2, m_mem_wr, m_mem_rd)};
            end
            if (lus) m_cnt = m_cnt + 1;
            m_mem_rd = m_exe_rd;
            m_mem_wr = m_exe_wr;
            if (fl || !v || lus) begin
                m_exe_rd = '0; m_exe_wr = 1'b0; m_exe_ld = 1'b0;
            end else begin
                m_exe_rd = rd; m_exe_wr = wr; m_exe_ld = ld;
            end
        end
        e.flags = m_flags;
        e.cnt   = m_cnt;
        exp_q.push_back(e);

        #1;
        got_s = stall_q.pop_front();
        seen_stall = load_use_stall;
        total++;
        if (load_use_stall !== got_s) begin
            bad++;
            $display("FAIL load_use_stall t=%0t got=%b want=%b", $time, load_use_stall, got_s);
        end

        @(posedge clk);
        #1;
        got_e = exp_q.pop_front();
        obs = {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard};
        total++;
        if (obs !== got_e.flags) begin
            bad++;
            $display("FAIL flags t=%0t got=%b want=%b", $time, obs, got_e.flags);
        end
        total++;
        if (stall_cnt !== got_e.cnt) begin
            bad++;
            $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, got_e.cnt);
        end
    endtask

    task automatic bubble();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nop();
        step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        step(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [4:0] rd, input logic [4:0] rs1);
        step(1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_flags(input string name, input logic [3:0] want);
        logic [3:0] obs;
        obs = {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard};
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s flags got=%b want=%b", name, obs, want);
        end
    endtask

    task automatic check_cnt(input string name, input logic [31:0] want);
        total++;
        if (stall_cnt !== want) begin
            bad++;
            $display("FAIL %s stall_cnt got=%0d want=%0d", name, stall_cnt, want);
        end
    endtask

    task automatic check_stall(input string name, input logic want);
        total++;
        if (seen_stall !== want) begin
            bad++;
            $display("FAIL %s load_use_stall got=%b want=%b", name, seen_stall, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; stall_mem = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_rd_addr = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset", 4'b0000);
        check_cnt("reset", 32'd0);
        total++;
        if (load_use_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset load_use_stall got=%b want=0", load_use_stall);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_exe_forward();
        bubble(); bubble();
        alu(5'd5, 5'd1, 5'd2);
        alu(5'd6, 5'd5, 5'd3);
        check_flags("exe_fwd", 4'b1000);
    endtask

    task automatic test_mem_forward();
        bubble(); bubble();
        alu(5'd5, 5'd1, 5'd2);
        nop();
        alu(5'd7, 5'd4, 5'd5);
        check_flags("mem_fwd", 4'b0001);
    endtask

    task automatic test_both_forward();
        bubble(); bubble();
        alu(5'd5, 5'd1, 5'd2);
        alu(5'd5, 5'd3, 5'd4);
        alu(5'd9, 5'd5, 5'd5);
        check_flags("both_fwd", 4'b1111);
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        bubble(); bubble();
        c0 = stall_cnt;
        load(5'd7, 5'd1);
        check_stall("lu_load", 1'b0);
        alu(5'd8, 5'd7, 5'd7);
        check_stall("lu_first", 1'b1);
        check_flags("lu_bubble", 4'b0000);
        check_cnt("lu_first", c0 + 32'd1);
        alu(5'd8, 5'd7, 5'd7);
        check_stall("lu_second", 1'b0);
        check_flags("lu_resolve", 4'b0101);
        check_cnt("lu_second", c0 + 32'd1);
    endtask

    task automatic test_x0_and_unused();
        bubble(); bubble();
        alu(5'd0, 5'd1, 5'd2);
        alu(5'd3, 5'd0, 5'd0);
        check_flags("x0", 4'b0000);
        alu(5'd5, 5'd1, 5'd2);
        step(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        check_flags("rs2_unused", 4'b0000);
    endtask

    task automatic test_stall_mem();
        logic [31:0] c0;
        bubble(); bubble();
        alu(5'd5, 5'd1, 5'd2);
        alu(5'd6, 5'd5, 5'd3);
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
        check_flags("smem_frozen", 4'b1000);
        step(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        check_flags("smem_resume", 4'b1010);
        bubble(); bubble();
        c0 = stall_cnt;
        load(5'd7, 5'd1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        check_stall("smem_lu_held", 1'b1);
        check_cnt("smem_lu_held", c0);
        alu(5'd8, 5'd7, 5'd2);
        check_cnt("smem_lu_adv", c0 + 32'd1);
        alu(5'd8, 5'd7, 5'd2);
        check_flags("smem_lu_resolve", 4'b0100);
    endtask

    task automatic test_flush();
        bubble(); bubble();
        alu(5'd5, 5'd1, 5'd2);
        step(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        check_flags("flush_bubble", 4'b0000);
        alu(5'd6, 5'd5, 5'd3);
        check_flags("flush_next", 4'b0100);
    endtask

    task automatic test_reset_mid();
        bubble(); bubble();
        load(5'd7, 5'd1);
        alu(5'd8, 5'd7, 5'd7);
        alu(5'd8, 5'd7, 5'd7);
        load(5'd9, 5'd1);
        @(negedge clk);
        id_valid = 1'b1; id_rs1_addr = 5'd9; id_rs2_addr = 5'd9;
        id_rs1_used = 1'b1; id_rs2_used = 1'b1; id_rd_addr = 5'd10;
        id_reg_write = 1'b1; id_mem_read = 1'b0; stall_mem = 1'b0; flush = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_flags("rst_mid", 4'b0000);
        check_cnt("rst_mid", 32'd0);
        total++;
        if (load_use_stall !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid load_use_stall got=%b want=0", load_use_stall);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        alu(5'd10, 5'd9, 5'd8);
        check_flags("rst_after", 4'b0000);
        check_stall("rst_after", 1'b0);
    endtask

    initial begin
        test_reset();
        test_exe_forward();
        test_mem_forward();
        test_both_forward();
        test_load_use();
        test_x0_and_unused();
        test_stall_mem();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
